// File: rtl/cpu54_pkg.sv
// cpu54_pkg: shared register-file widths, named register addresses and word typedefs
package cpu54_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM = 32;
  localparam int DATA_W = 32;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;
  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA = 5'd31;
endpackage

// File: rtl/wr_decoder5_32.sv
// wr_decoder5_32: 5-to-32 one-hot write-enable decoder, bit 0 masked so register 0 is never written
//   iAddr: destination register, iEn: write enable, oWe: per-register write enables
module wr_decoder5_32
  import cpu54_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] iAddr,
  input  logic                  iEn,
  output logic [REG_NUM-1:0]    oWe
);
  always_comb begin
    oWe = '0;
    oWe[iAddr] = iEn;
    oWe[REG_ZERO] = 1'b0;
  end
endmodule

// File: rtl/reg_file32.sv
// reg_file32: 32 x 32-bit register file, two combinational read ports, one write port, r0 reads zero
//   iClk/iRst_n: clock and async active-low reset; iWe/iWAddr/iWData: writeback port
//   iRAddr1/iRAddr2 -> oRData1/oRData2: operand reads; oWrote: pulse the cycle after a committed write
//   REG_FILE_BYPASS_EN: when defined, a read of the address being written returns iWData that cycle
module reg_file32
  import cpu54_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iWe,
  input  logic [ADDR_W-1:0] iWAddr,
  input  logic [DATA_W-1:0] iWData,
  input  logic [ADDR_W-1:0] iRAddr1,
  input  logic [ADDR_W-1:0] iRAddr2,
  output logic [DATA_W-1:0] oRData1,
  output logic [DATA_W-1:0] oRData2,
  output logic              oWrote
);
  localparam int NREG = 1 << ADDR_W;
  logic [NREG-1:0] we;
  logic [DATA_W-1:0] regs [NREG];
  wr_decoder5_32 uDec (.iAddr(iWAddr), .iEn(iWe), .oWe(we));
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      oWrote <= 1'b0;
    end else begin
      for (int i = 1; i < NREG; i++) if (we[i]) regs[i] <= iWData;
      oWrote <= |we;
    end
  end
`ifdef REG_FILE_BYPASS_EN
  assign oRData1 = (iRAddr1 == REG_ZERO) ? '0 : (iWe && iRAddr1 == iWAddr) ? iWData : regs[iRAddr1];
  assign oRData2 = (iRAddr2 == REG_ZERO) ? '0 : (iWe && iRAddr2 == iWAddr) ? iWData : regs[iRAddr2];
`else
  assign oRData1 = (iRAddr1 == REG_ZERO) ? '0 : regs[iRAddr1];
  assign oRData2 = (iRAddr2 == REG_ZERO) ? '0 : regs[iRAddr2];
`endif
endmodule
